// File: rtl/sram22_param_model_pkg.sv
// Shared definitions for the sram22 behavioural model.
//   clr_state_e : clear-sequencer states
//   seg_width   : write-mask segment width for a word/mask pairing
//   params_ok   : legality of the DATA_WIDTH / WMASK_WIDTH / READ_LATENCY set
package sram22_model_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int seg_width(input int data_w, input int mask_w);
    return (mask_w > 0) ? data_w / mask_w : 0;
  endfunction

  function automatic bit params_ok(input int data_w, input int mask_w, input int lat);
    return (mask_w > 0) && (data_w % mask_w == 0) && (lat == 1 || lat == 2);
  endfunction

endpackage

// File: rtl/sram22_param_model_if.sv
// Request/response bundle for the sram22 model.
//   master: drives we/wmask/addr/din/sae_muxed, observes read results and busy
//   slave : the memory side
interface sram22_param_model_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 4
) ();
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic                   sae_muxed;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   sae_int;
  logic                   sense_err;
  logic                   busy;

  modport master (
    output we, wmask, addr, din, sae_muxed,
    input  dout, dout_valid, sae_int, sense_err, busy
  );

  modport slave (
    input  we, wmask, addr, din, sae_muxed,
    output dout, dout_valid, sae_int, sense_err, busy
  );
endinterface

// File: rtl/sram22_param_model_clear_ctrl.sv
// Post-reset zero-fill sequencer.
//   clk, rst  : clock, async active-high reset
//   busy      : high while the fill runs (user requests are dropped)
//   clr_we    : fill write strobe, one word per cycle
//   clr_addr  : fill address, 0 .. RAM_DEPTH-1, no wrap
module sram22_clear_ctrl
  import sram22_model_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  localparam clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Last address is written in the same cycle we leave CLEAR, so the fill
  // takes exactly RAM_DEPTH cycles and the counter parks at the top.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt == '1) state_nxt = IDLE;
        else           cnt_nxt   = cnt + 1'b1;
      end
      default: ;
    endcase
  end

  assign clr_addr = cnt;
endmodule

// File: rtl/sram22_param_model.sv
// Single-port SRAM behavioural model with masked writes, 1- or 2-cycle read
// latency, sense-amp enable check and optional zero fill after reset.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of sram22_param_model_if
//              (we/wmask/addr/din/sae_muxed in; dout/dout_valid/sae_int/
//               sense_err/busy out)
module sram22_param_model
  import sram22_model_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int WMASK_WIDTH    = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                 clk,
  input logic                 rst,
  sram22_param_model_if.slave bus
);
  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int SEG_W     = seg_width(DATA_WIDTH, WMASK_WIDTH);

  if (!params_ok(DATA_WIDTH, WMASK_WIDTH, READ_LATENCY)) begin : g_bad_params
    $error("sram22_param_model: DATA_WIDTH must divide by WMASK_WIDTH and READ_LATENCY must be 1 or 2");
  end

  logic                  busy, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram22_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Requests seen while reset is held are ignored too, so a no-fill
  // configuration keeps its contents across a reset pulse.
  logic wr_acc, rd_acc;
  assign wr_acc = !rst && !busy &&  bus.we;
  assign rd_acc = !rst && !busy && !bus.we;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Fill sequencer owns the write port while busy; user writes otherwise.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < WMASK_WIDTH; k++)
        if (bus.wmask[k]) mem[bus.addr][k*SEG_W +: SEG_W] <= bus.din[k*SEG_W +: SEG_W];
    end
  end

  // Array word sampled at the accept edge; later writes cannot disturb it.
  logic [DATA_WIDTH-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (rd_acc) rd_q <= mem[bus.addr];
  end

  // vld_pipe[0] is the sense-amp enable cycle; capture happens at its end.
  logic [READ_LATENCY:0] vld_pipe;
  logic [READ_LATENCY:1] err_pipe;
  logic [DATA_WIDTH-1:0] dat_pipe [1:READ_LATENCY];
  logic [DATA_WIDTH-1:0] cap_data;

  // A capture without the muxed enable returns garbage; model it as all-X.
  assign cap_data = bus.sae_muxed ? rd_q : {DATA_WIDTH{1'bx}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int s = 1; s <= READ_LATENCY; s++) dat_pipe[s] <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      vld_pipe[1] <= vld_pipe[0];
      err_pipe[1] <= vld_pipe[0] && !bus.sae_muxed;
      if (vld_pipe[0]) dat_pipe[1] <= cap_data;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        err_pipe[s] <= err_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign bus.sae_int    = vld_pipe[0];
  assign bus.dout_valid = vld_pipe[READ_LATENCY];
  assign bus.sense_err  = err_pipe[READ_LATENCY];
  assign bus.dout       = dat_pipe[READ_LATENCY];
  assign bus.busy       = busy;
endmodule

// File: tb/tb_sram22_param_model.sv
// Directed bench: three model instances share one stimulus bus.
//   a: READ_LATENCY=1, fill on reset
//   b: READ_LATENCY=2, fill on reset
//   c: READ_LATENCY=1, no fill
module tb_sram22_param_model;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we;
  logic [3:0]  wmask;
  logic [5:0]  addr;
  logic [31:0] din;
  logic        sae_muxed;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        c_busy_seen = 1'b0;

  always #5 clk = ~clk;

  sram22_param_model_if ifa ();
  sram22_param_model_if ifb ();
  sram22_param_model_if ifc ();

  assign ifa.we = we;  assign ifa.wmask = wmask;  assign ifa.addr = addr;
  assign ifa.din = din;  assign ifa.sae_muxed = sae_muxed;
  assign ifb.we = we;  assign ifb.wmask = wmask;  assign ifb.addr = addr;
  assign ifb.din = din;  assign ifb.sae_muxed = sae_muxed;
  assign ifc.we = we;  assign ifc.wmask = wmask;  assign ifc.addr = addr;
  assign ifc.din = din;  assign ifc.sae_muxed = sae_muxed;

  sram22_param_model #(.READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  sram22_param_model #(.READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  sram22_param_model #(.READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  always @(negedge clk) if (ifc.busy) c_busy_seen <= 1'b1;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    we = 1'b1; wmask = 4'h0; addr = 6'd0; din = 32'h0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; wmask = m; addr = a; din = d;
  endtask

  task automatic rd(input logic [5:0] a);
    we = 1'b0; wmask = 4'h0; addr = a; din = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    idle(); sae_muxed = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (ifa.dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0", ifa.dout); end
    n_chk++; if ({ifa.dout_valid, ifa.sae_int, ifa.sense_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {ifa.dout_valid, ifa.sae_int, ifa.sense_err}); end
    n_chk++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_a got %b want 1", ifa.busy); end
    n_chk++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_c got %b want 0", ifc.busy); end
    rst = 1'b0;
    n = 0;
    while (ifa.busy && n < 200) begin cyc(); n++; end
    n_chk++; if (n != 64) begin n_fail++; $display("FAIL clear_len got %0d want 64", n); end
    n_chk++; if (ifb.busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_b got %b want 0", ifb.busy); end
  endtask

  task automatic test_clear_zero();
    for (int i = 0; i < 66; i++) begin
      if (i < 64) rd(6'(i)); else idle();
      cyc();
      if (i >= 1 && i <= 64) begin
        n_chk++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 32'h0) begin
          n_fail++; $display("FAIL zero_a addr %0d got v=%b d=%h want v=1 d=0", i-1, ifa.dout_valid, ifa.dout);
        end
      end
      if (i >= 2) begin
        n_chk++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== 32'h0) begin
          n_fail++; $display("FAIL zero_b addr %0d got v=%b d=%h want v=1 d=0", i-2, ifb.dout_valid, ifb.dout);
        end
      end
    end
  endtask

  task automatic test_mask();
    wr(6'd5, 32'hDEADBEEF, 4'b1111); cyc();
    wr(6'd5, 32'h11223344, 4'b0101); cyc();
    wr(6'd40, 32'hCAFE0000, 4'b1111); cyc();
    n_chk++; if (ifa.dout !== 32'h0 || ifa.dout_valid !== 1'b0 || ifa.sae_int !== 1'b0) begin
      n_fail++; $display("FAIL write_quiet got d=%h v=%b s=%b want 0/0/0", ifa.dout, ifa.dout_valid, ifa.sae_int); end
    rd(6'd5); cyc();
    n_chk++; if (ifa.sae_int !== 1'b1 || ifa.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL mask_accept got s=%b v=%b want s=1 v=0", ifa.sae_int, ifa.dout_valid); end
    idle(); cyc();
    n_chk++; if (ifa.dout_valid !== 1'b1 || ifa.dout !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL mask_a got v=%b d=%h want v=1 d=de22be44", ifa.dout_valid, ifa.dout); end
    n_chk++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL mask_c got v=%b d=%h want v=1 d=de22be44", ifc.dout_valid, ifc.dout); end
    n_chk++; if (ifb.dout_valid !== 1'b0 || ifa.sae_int !== 1'b0) begin
      n_fail++; $display("FAIL mask_lat2_early got bv=%b as=%b want 0/0", ifb.dout_valid, ifa.sae_int); end
    cyc();
    n_chk++; if (ifa.dout_valid !== 1'b0) begin n_fail++; $display("FAIL mask_a_pulse got v=%b want 0", ifa.dout_valid); end
    n_chk++; if (ifb.dout_valid !== 1'b1 || ifb.dout !== 32'hDE22BE44) begin
      n_fail++; $display("FAIL mask_b got v=%b d=%h want v=1 d=de22be44", ifb.dout_valid, ifb.dout); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_dat [6];
    logic [31:0] b_dat [6];
    logic [5:0]  a_vld, a_sae, b_vld;
    a_dat = '{32'hDE22BE44, 32'h1111, 32'h2222, 32'h2222, 32'h3333, 32'h3333};
    b_dat = '{32'hDE22BE44, 32'hDE22BE44, 32'h1111, 32'h2222, 32'h2222, 32'h3333};
    a_vld = 6'b010110;  // bit s = step s
    a_sae = 6'b001011;
    b_vld = 6'b101100;
    wr(6'd1, 32'h1111, 4'hF); cyc();
    wr(6'd2, 32'h2222, 4'hF); cyc();
    wr(6'd3, 32'h3333, 4'hF); cyc();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: rd(6'd1);
        1: rd(6'd2);
        2: wr(6'd9, 32'h99, 4'hF);
        3: rd(6'd3);
        default: idle();
      endcase
      cyc();
      n_chk++;
      if (ifa.dout_valid !== a_vld[s] || ifa.dout !== a_dat[s] || ifa.sae_int !== a_sae[s]) begin
        n_fail++; $display("FAIL b2b_a step %0d got v=%b d=%h s=%b want v=%b d=%h s=%b", s,
          ifa.dout_valid, ifa.dout, ifa.sae_int, a_vld[s], a_dat[s], a_sae[s]);
      end
      n_chk++;
      if (ifb.dout_valid !== b_vld[s] || ifb.dout !== b_dat[s]) begin
        n_fail++; $display("FAIL b2b_b step %0d got v=%b d=%h want v=%b d=%h", s,
          ifb.dout_valid, ifb.dout, b_vld[s], b_dat[s]);
      end
    end
    rd(6'd9); cyc(); idle(); cyc();
    n_chk++; if (ifa.dout !== 32'h99) begin n_fail++; $display("FAIL b2b_wr9 got %h want 99", ifa.dout); end
  endtask

  task automatic test_sense_err();
    rd(6'd5); cyc();
    idle(); sae_muxed = 1'b0; cyc();
    sae_muxed = 1'b1;
    n_chk++; if (ifa.sense_err !== 1'b1 || ifa.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL serr_a got e=%b v=%b want 1/1", ifa.sense_err, ifa.dout_valid); end
    n_chk++; if (ifb.dout_valid !== 1'b0 || ifb.sense_err !== 1'b0) begin
      n_fail++; $display("FAIL serr_b_early got e=%b v=%b want 0/0", ifb.sense_err, ifb.dout_valid); end
    cyc();
    n_chk++; if (ifa.sense_err !== 1'b0 || ifa.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL serr_a_pulse got e=%b v=%b want 0/0", ifa.sense_err, ifa.dout_valid); end
    n_chk++; if (ifb.sense_err !== 1'b1 || ifb.dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL serr_b got e=%b v=%b want 1/1", ifb.sense_err, ifb.dout_valid); end
    cyc();
    n_chk++; if (ifb.sense_err !== 1'b0) begin n_fail++; $display("FAIL serr_b_pulse got %b want 0", ifb.sense_err); end
  endtask

  task automatic test_reset_mid_clear();
    int n, vcnt;
    logic [5:0] chk_addr [3];
    chk_addr = '{6'd40, 6'd5, 6'd9};
    // read in flight when reset hits
    rd(6'd5); cyc();
    n_chk++; if (ifa.sae_int !== 1'b1) begin n_fail++; $display("FAIL inflight_sae got %b want 1", ifa.sae_int); end
    rst = 1'b1; #1;
    n_chk++; if (ifa.sae_int !== 1'b0 || ifa.dout !== 32'h0 || ifa.busy !== 1'b1 || ifb.dout !== 32'h0) begin
      n_fail++; $display("FAIL async_rst got s=%b ad=%h busy=%b bd=%h want 0/0/1/0", ifa.sae_int, ifa.dout, ifa.busy, ifb.dout); end
    #2 rst = 1'b0;
    idle();
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) rd(6'd5);
      cyc();
      if (ifa.dout_valid || ifb.dout_valid) vcnt++;
    end
    // abort at clear cycle 20 with a read pending
    rst = 1'b1; #1;
    n_chk++; if (ifa.busy !== 1'b1 || ifa.dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst got busy=%b v=%b want 1/0", ifa.busy, ifa.dout_valid); end
    #2 rst = 1'b0;
    n = 0;
    while (ifa.busy && n < 200) begin
      cyc(); n++;
      if (ifa.dout_valid || ifb.dout_valid) vcnt++;
    end
    idle();
    n_chk++; if (n != 64) begin n_fail++; $display("FAIL restart_len got %0d want 64", n); end
    repeat (3) begin
      cyc();
      if (ifa.dout_valid || ifb.dout_valid) vcnt++;
    end
    n_chk++; if (vcnt != 0) begin n_fail++; $display("FAIL dropped_reads got %0d pulses want 0", vcnt); end
    for (int i = 0; i < 3; i++) begin
      rd(chk_addr[i]); cyc(); idle(); cyc();
      n_chk++;
      if (ifa.dout_valid !== 1'b1 || ifa.dout !== 32'h0) begin
        n_fail++; $display("FAIL refill addr %0d got v=%b d=%h want v=1 d=0", chk_addr[i], ifa.dout_valid, ifa.dout);
      end
    end
  endtask

  task automatic test_no_clear();
    wr(6'd7, 32'hA5A5A5A5, 4'hF); cyc();
    idle();
    rst = 1'b1; #2 rst = 1'b0;
    n_chk++; if (ifc.dout !== 32'h0 || ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL noclr_rst got d=%h busy=%b want 0/0", ifc.dout, ifc.busy); end
    rd(6'd7); cyc(); idle(); cyc();
    n_chk++; if (ifc.dout_valid !== 1'b1 || ifc.dout !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL noclr_keep got v=%b d=%h want v=1 d=a5a5a5a5", ifc.dout_valid, ifc.dout); end
    cyc();
    n_chk++; if (c_busy_seen !== 1'b0) begin n_fail++; $display("FAIL noclr_busy got %b want 0", c_busy_seen); end
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_mask();
    test_back_to_back();
    test_sense_err();
    test_reset_mid_clear();
    test_no_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
